// File: rtl/i_cache_pkg.sv
// i_cache_pkg: shared widths, FSM states and word-alignment helper for i_cache.
package i_cache_pkg;
  typedef enum logic {IDLE, FILL} state_e;
  function automatic int idx_w(input int cache_size);
    return $clog2(cache_size);
  endfunction
  function automatic int tag_w(input int addr_width, input int cache_size);
    return addr_width - $clog2(cache_size) - 2;
  endfunction
  function automatic logic [63:0] word_align(input logic [63:0] a);
    return a & ~64'd3;
  endfunction
endpackage

// File: rtl/i_cache_array.sv
// i_cache_array: valid/tag/data line storage with async read, one write port and clear-all.
module i_cache_array
  import i_cache_pkg::*;
#(
  parameter int CACHE_SIZE = 1024,
  parameter int IW = idx_w(CACHE_SIZE),
  parameter int TW = 20
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  logic [31:0]   wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_data
);
  logic [CACHE_SIZE-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q [CACHE_SIZE];
  logic [31:0] data_q [CACHE_SIZE];
  // clear wins over a same-cycle write so a killed fill never leaves a live line
  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[wr_idx] = 1'b1;
    if (clear) valid_d = '0;
  end
  always_ff @(posedge clk) valid_q <= valid_d;
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx] <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag = tag_q[rd_idx];
  assign rd_data = data_q[rd_idx];
endmodule

// File: rtl/i_cache.sv
// i_cache: direct-mapped read-only instruction cache, one 32-bit word per line.
// Define ICACHE_FLUSH_EN to add a flush input that invalidates all lines and abandons a fill.
module i_cache
  import i_cache_pkg::*;
#(
  parameter int CACHE_SIZE = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef ICACHE_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  read_request,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  read_response,
  output logic [31:0]           read_data,
  output logic                  memory_read_request,
  input  logic                  memory_read_response,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  input  logic [31:0]           memory_read_data
);
  localparam int IW = idx_w(CACHE_SIZE);
  localparam int TW = tag_w(ADDR_WIDTH, CACHE_SIZE);
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic kill, hit, miss, fill_we, rd_valid;
  logic [TW-1:0] rd_tag;
  logic [31:0] rd_data;
`ifdef ICACHE_FLUSH_EN
  assign kill = !reset || flush;
`else
  assign kill = !reset;
`endif
  i_cache_array #(.CACHE_SIZE(CACHE_SIZE), .IW(IW), .TW(TW)) u_array (
    .clk(clk),
    .clear(kill),
    .we(fill_we && !kill),
    .wr_idx(miss_addr_q[IW+1:2]),
    .wr_tag(miss_addr_q[ADDR_WIDTH-1:IW+2]),
    .wr_data(memory_read_data),
    .rd_idx(addr[IW+1:2]),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(rd_data)
  );
  always_comb begin
    hit = state_q == IDLE && read_request && rd_valid && rd_tag == addr[ADDR_WIDTH-1:IW+2];
    miss = state_q == IDLE && read_request && !hit;
    fill_we = state_q == FILL && memory_read_response;
    state_d = fill_we ? IDLE : miss ? FILL : state_q;
    miss_addr_d = miss ? ADDR_WIDTH'(word_align(64'(addr))) : miss_addr_q;
    read_response = hit;
    read_data = hit ? rd_data : '0;
    memory_read_request = state_q == FILL;
    memory_addr = memory_read_request ? miss_addr_q : '0;
  end
  always_ff @(posedge clk) begin
    state_q <= kill ? IDLE : state_d;
    miss_addr_q <= kill ? '0 : miss_addr_d;
  end
endmodule

// File: tb/tb_i_cache.sv
// tb_i_cache: directed table, corner-case sequences and randomized fetches vs a line-map model.
module tb_i_cache;
  logic clk = 0, reset = 0, read_request = 0, memory_read_response = 0;
  logic [31:0] addr = 0, memory_read_data = 0;
  logic read_response, memory_read_request;
  logic [31:0] read_data, memory_addr;
`ifdef ICACHE_FLUSH_EN
  logic flush = 0;
`endif
  int passed = 0, total = 0;
  int lat = 1, req_cnt = 0, wait_cnt = 0;
  logic prev_req = 0, force_rsp = 0;
  logic [31:0] last_maddr = 0;
  logic [31:0] model [int];

  typedef struct {
    logic [31:0] a;
    logic        hit;
    logic [31:0] maddr;
    logic [31:0] data;
  } vec_t;

  always #5 clk = ~clk;

  i_cache dut (
    .clk(clk),
    .reset(reset),
`ifdef ICACHE_FLUSH_EN
    .flush(flush),
`endif
    .read_request(read_request),
    .addr(addr),
    .read_response(read_response),
    .read_data(read_data),
    .memory_read_request(memory_read_request),
    .memory_read_response(memory_read_response),
    .memory_addr(memory_addr),
    .memory_read_data(memory_read_data)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 0 ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // backing memory: counts new requests, answers after lat cycles, can inject a stray pulse
  initial forever begin
    @(negedge clk);
    memory_read_response = 0;
    if (memory_read_request && !prev_req) begin
      req_cnt++;
      last_maddr = memory_addr;
    end
    prev_req = memory_read_request;
    if (force_rsp) begin
      memory_read_response = 1;
      memory_read_data = 32'hDEAD_BEEF;
      force_rsp = 0;
    end else if (memory_read_request) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        memory_read_response = 1;
        memory_read_data = mem_word(memory_addr);
        wait_cnt = 0;
      end
    end else wait_cnt = 0;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int w, output int r,
                       output logic [31:0] ma);
    int r0;
    r0 = req_cnt;
    read_request = 1;
    addr = a;
    w = 0;
    #1;
    while (!read_response && w < 100) begin
      step();
      w++;
    end
    check("fetch_rsp", read_response, 1);
    check("fetch_mreq_at_hit", memory_read_request, 0);
    d = read_data;
    r = req_cnt - r0;
    ma = last_maddr;
    step();
  endtask

  task automatic wait_mreq();
    int w;
    w = 0;
    while (!memory_read_request && w < 20) begin
      step();
      w++;
    end
    check("mreq_seen", memory_read_request, 1);
  endtask

  task automatic kill_mid_fill(input logic use_flush, input logic [31:0] miss_a);
    logic [31:0] d, ma;
    int w, r;
    lat = 6;
    read_request = 1;
    addr = miss_a;
    wait_mreq();
    step();
    read_request = 0;
`ifdef ICACHE_FLUSH_EN
    if (use_flush) flush = 1;
    else reset = 0;
`else
    reset = 0;
`endif
    step();
    check("kill_mreq_drop", memory_read_request, 0);
    check("kill_maddr", memory_addr, 0);
    reset = 1;
`ifdef ICACHE_FLUSH_EN
    flush = 0;
`endif
    force_rsp = 1;
    step();
    step();
    check("late_rsp_ignored", memory_read_request, 0);
    lat = 2;
    fetch(32'h0, d, w, r, ma);
    check("kill_0_misses", r, 1);
    check("kill_0_data", d, 32'h13);
    fetch(miss_a, d, w, r, ma);
    check("kill_refill_reqs", r, 1);
    check("kill_refill_data", d, mem_word(miss_a));
  endtask

  initial begin
    logic [31:0] d, ma;
    int w, r;
    vec_t tbl[11];
    tbl[0]  = '{32'h0000, 1'b1, 32'h0,    32'h0000_0013};
    tbl[1]  = '{32'h0004, 1'b0, 32'h4,    32'h0004_FFFB};
    tbl[2]  = '{32'h0008, 1'b0, 32'h8,    32'h0008_FFF7};
    tbl[3]  = '{32'h0004, 1'b1, 32'h0,    32'h0004_FFFB};
    tbl[4]  = '{32'h0006, 1'b1, 32'h0,    32'h0004_FFFB};
    tbl[5]  = '{32'h000E, 1'b0, 32'hC,    32'h000C_FFF3};
    tbl[6]  = '{32'h000C, 1'b1, 32'h0,    32'h000C_FFF3};
    tbl[7]  = '{32'h1000, 1'b0, 32'h1000, 32'h1000_EFFF};
    tbl[8]  = '{32'h0000, 1'b0, 32'h0,    32'h0000_0013};
    tbl[9]  = '{32'h1002, 1'b0, 32'h1000, 32'h1000_EFFF};
    tbl[10] = '{32'h0008, 1'b1, 32'h0,    32'h0008_FFF7};

    repeat (3) step();
    check("rst_read_response", read_response, 0);
    check("rst_mem_req", memory_read_request, 0);
    check("rst_mem_addr", memory_addr, 0);
    check("rst_read_data", read_data, 0);
    reset = 1;
    step();

    fetch(32'h0, d, w, r, ma);
    check("first_data", d, 32'h13);
    check("first_reqs", r, 1);
    check("first_maddr", ma, 0);
    check("first_penalty", w, lat + 1);
    r = req_cnt;
    repeat (4) begin
      check("hold_rsp", read_response, 1);
      check("hold_no_mreq", memory_read_request, 0);
      step();
    end
    check("hold_reqs", req_cnt - r, 0);

    foreach (tbl[i]) begin
      lat = 1 + i % 3;
      fetch(tbl[i].a, d, w, r, ma);
      check($sformatf("tbl%0d_data", i), d, tbl[i].data);
      check($sformatf("tbl%0d_hit", i), r == 0, tbl[i].hit);
      check($sformatf("tbl%0d_wait", i), w, tbl[i].hit ? 0 : lat + 1);
      if (!tbl[i].hit) check($sformatf("tbl%0d_maddr", i), ma, tbl[i].maddr);
    end

    // address moves to a cached line while 0x10 is filling
    fetch(32'h0, d, w, r, ma);
    lat = 4;
    r = req_cnt;
    read_request = 1;
    addr = 32'h10;
    wait_mreq();
    check("mid_maddr", memory_addr, 32'h10);
    check("mid_no_rsp_data", read_data, 0);
    addr = 32'h0;
    w = 0;
    while (!read_response && w < 20) begin
      step();
      w++;
    end
    check("mid_hit_rsp", read_response, 1);
    check("mid_hit_data", read_data, 32'h13);
    check("mid_one_fill", req_cnt - r, 1);
    fetch(32'h10, d, w, r, ma);
    check("mid_later_hit", r, 0);
    check("mid_later_data", d, 32'h0010_FFEF);

    // request withdrawn during a fill: fill still lands
    read_request = 1;
    addr = 32'h20;
    wait_mreq();
    read_request = 0;
    repeat (7) step();
    check("drop_fill_done", memory_read_request, 0);
    fetch(32'h20, d, w, r, ma);
    check("drop_then_hit", r, 0);
    check("drop_then_wait", w, 0);
    check("drop_then_data", d, 32'h0020_FFDF);

    kill_mid_fill(1'b0, 32'h14);
`ifdef ICACHE_FLUSH_EN
    kill_mid_fill(1'b1, 32'h18);
`endif

    reset = 0;
    read_request = 0;
    step();
    reset = 1;
    model.delete();
    repeat (150) begin
      logic [31:0] a, al;
      int ix;
      logic h;
      a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      lat = $urandom_range(1, 4);
      al = a & ~32'd3;
      ix = int'(al[11:2]);
      h = model.exists(ix) && model[ix] == al;
      fetch(a, d, w, r, ma);
      check("rnd_data", d, mem_word(al));
      check("rnd_reqs", r, h ? 0 : 1);
      check("rnd_wait", w, h ? 0 : lat + 1);
      if (!h) check("rnd_maddr", ma, al);
      model[ix] = al;
      if ($urandom_range(0, 1) == 1) begin
        read_request = 0;
        step();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/i_cache.md
Name: i_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and a word-wide backing memory.
- One 32-bit word per line; hits return data combinationally in the request cycle.
- Misses issue a single-word read to memory, fill the line, then complete as a hit.
- No write path; memory is assumed immutable while the cache is in use.

Parameters:
- CACHE_SIZE, 1024: number of 32-bit lines; power of two, ≥2.
- ADDR_WIDTH, 32: byte address width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- read_request  in  1  fetch request; level-held by the CPU until read_response.
- addr  in  32  fetch byte address; addr[1:0] ignored.
- read_response  out  1  read_data valid this cycle.
- read_data  out  32  aligned word containing addr.
- memory_read_request  out  1  line-fill read request to memory.
- memory_read_response  in  1  one-cycle pulse; memory_read_data valid.
- memory_addr  out  32  word-aligned fill address.
- memory_read_data  in  32  fill data.

Behaviour:
- Address split, with IDX = log2(CACHE_SIZE):
  - offset = addr[1:0], ignored.
  - index = addr[IDX+1:2].
  - tag = addr[31:IDX+2].
- Storage: valid[CACHE_SIZE], tag array, data array.
  - Valid and tag are flops with asynchronous read.
  - Data array: asynchronous read, synchronous write.
- Reset (reset==0 at a clk edge):
  - All valid bits cleared; FSM goes to IDLE.
  - Outputs: read_response=0, memory_read_request=0, memory_addr=0, read_data=0.
- hit = read_request & valid[index] & (tag_array[index]==tag), evaluated only in IDLE.
- IDLE:
  - On hit: read_response=1 and read_data=data[index] in the same cycle (0 wait states).
  - On miss with read_request: latch {addr[31:2],2'b00} into miss_addr and go to FILL; read_response=0.
  - When read_response=0, read_data is 0.
- FILL:
  - memory_read_request=1 and memory_addr=miss_addr, both held stable until memory_read_response.
  - On memory_read_response: write data, tag and valid for miss_addr's index; drop memory_read_request next cycle; go to IDLE.
  - Memory latency is arbitrary, ≥1 cycle.
- Post-fill: the request completes as an IDLE hit one cycle after the response, so miss penalty = memory latency + 1 cycle.
- Addr change during FILL: the fill completes for miss_addr regardless. IDLE then re-evaluates the current addr, which may hit or trigger a new miss.
- read_request dropped during FILL: the fill still completes; there is no abort.
- Conflict: a line with the same index but a different tag is overwritten.
- Misaligned addresses (e.g. 0x6, 0xE): return the aligned word (0x4, 0xC). Halfword extraction is the fetch stage's job.
- Reset mid-FILL: the fill is abandoned, memory_read_request drops on the same edge, and a late memory_read_response is ignored.

Optional Feature:
- Macro ICACHE_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 at a clk edge clears all valid bits and forces IDLE; any fill is abandoned as on reset.
  - Flush has priority over a same-cycle fill write.
- Undefined: no flush port; valid bits are cleared only by reset.

Decomposition:
- Shared package i_cache_pkg holds:
  - the IDX/TAG width functions computed from CACHE_SIZE;
  - the FSM enum typedef {IDLE, FILL};
  - the word-alignment helper.
- One natural sub-module: i_cache_array (valid/tag/data storage, async read, single write port, clear-all input).
- FSM and hit logic stay in i_cache.

Test Plan:
- Reset, then read_request=1, addr=0x0, memory word 0x0=0x00000013:
  - memory_read_request asserted with memory_addr=0x0;
  - after the response, read_response=1 with read_data=0x00000013;
  - no further memory requests while addr is held.
- Sequential addr 0x4 then 0x8, 8 ns apart:
  - each misses once and fills;
  - re-requesting 0x4 afterwards hits in 0 cycles with memory_read_request=0.
- addr=0x6 after 0x4 is filled: immediate hit returning the 0x4 word. addr=0xE: miss with memory_addr=0xC.
- Conflict: fill 0x0, then 0x1000 (same index for CACHE_SIZE=1024), then 0x0 again → three misses, with correct data each time.
- addr changed from 0x10 to 0x0 (cached) mid-FILL: the fill of 0x10 completes, then 0x0 hits; a later 0x10 hits.
- Reset asserted mid-FILL:
  - memory_read_request drops;
  - after reset, address 0x0 misses again because its valid bit was cleared.
  - With ICACHE_FLUSH_EN, the same sequence using flush behaves identically.
